div_seq: RTL and testbench
==========================

# div_seq

Multi-cycle integer divide sequencer for the EX stage. It serves `div`/`divu` by running a 32-iteration restoring division FSM. It holds the result for the EX stage until the EX stage drops its request. EX drives `stallreq` from `busy_o` so the pipeline control unit freezes stages while division runs; the `{remainder, quotient}` result is written to HI/LO through the normal whilo path.

## Interface
- No parameters; widths fixed: operand 32, result 64.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `signed_div_i` in 1: 1 = signed (`div`), 0 = unsigned (`divu`).
- `opdata1_i` in 32: dividend.
- `opdata2_i` in 32: divisor.
- `start_i` in 1: request; held high by EX until `ready_o` seen.
- `annul_i` in 1: abort current operation (flush/exception).
- `result_o` out 64: `[63:32]` remainder (HI), `[31:0]` quotient (LO).
- `ready_o` out 1: result valid.
- `busy_o` out 1: division in progress; EX ORs into `stallreq`.

## Operation
- States: FREE, BYZERO, ON, END. Reset → FREE; `result_o`=0, `ready_o`=0, `busy_o`=0, counter=0.
- `busy_o` = 1 in BYZERO and ON only. `ready_o` = 1 in END only. `result_o` = 0 outside END.
- **FREE**
  - `start_i`=1, `annul_i`=0, divisor=0 → BYZERO.
  - `start_i`=1, `annul_i`=0, divisor≠0 → ON. Latch magnitudes: if signed and operand negative, use two's-complement negation; otherwise use raw. Latch sign flags. Clear counter.
  - Otherwise stay.
- **BYZERO**: next edge → END with result 0.
- **ON**
  - Each cycle performs one restoring step: shift the partial remainder left, bringing in the next dividend bit (MSB first).
  - If partial remainder ≥ divisor magnitude (33-bit compare), subtract and set the quotient bit to 1; otherwise set it to 0.
  - Counter increments 0..31; the step with counter=31 → END.
- **END**
  - Quotient is negated if signed and operand signs differ.
  - Remainder is negated if signed and dividend negative.
  - Result is held while `start_i`=1. `start_i`=0 → FREE.
- `annul_i`=1 in any state → FREE next edge, results cleared. Annul beats start.
- 0x80000000 / 0xFFFFFFFF signed: quotient 0x80000000, remainder 0 (wraps; no trap).
- Operands are sampled only on the FREE→ON/BYZERO edge; later changes on `opdata*_i` are ignored.
- `rst` overrides everything, including mid-operation.

## Timing
- Start sampled at edge 1 → ON. Iterations at edges 2..33; edge 33 enters END. `ready_o` is high from edge 33 until the edge after `start_i` falls.
- Divide-by-zero: BYZERO after edge 1, END after edge 2.
- After END→FREE, a new `start_i` can be accepted on the very next edge. A back-to-back divide costs exactly one FREE cycle.
- Annul has 1-cycle latency to FREE. `busy_o` drops the same edge.

## Configuration
- `DIV_EARLY_EXIT_EN` defined:
  - In FREE with valid start, divisor≠0 and |dividend| < |divisor| (unsigned compare of magnitudes) → END at edge 1.
  - Quotient 0, remainder = original `opdata1_i`; `busy_o` never asserts.
- Not defined: all nonzero divisors take the full 32 iterations.

## Test plan
- Unsigned 100 / 7, start held → `ready_o` after edge 33; `result_o` = {0x00000002, 0x0000000E}; FREE one edge after `start_i` drops.
- Signed −7 / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 0x80000000 / −1 → {0, 0x80000000}.
- Divisor 0 → `busy_o` for one cycle, `ready_o` after edge 2, result 0.
- `annul_i` pulsed at iteration 10 → FREE next edge, `busy_o`=`ready_o`=0, result 0; next start gives a correct full-latency result.
- `rst` asserted mid-ON → all outputs 0, state FREE.
- `DIV_EARLY_EXIT_EN`: 3 / 10 → `ready_o` after edge 1, result {3, 0}. Without the macro → ready after edge 33, same result.

Source files
------------

// File: rtl/div_seq.sv
// div_seq: multi-cycle 32/32 integer divider for the EX stage.
// Runs a 32-step restoring division (signed or unsigned), reports busy_o while
// iterating and holds {remainder, quotient} on result_o until start_i drops.
// Optional build macro DIV_EARLY_EXIT_EN: finish in one cycle when the dividend
// magnitude is below the divisor magnitude.
module div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        busy_o
);

  localparam logic [1:0] StFree   = 2'd0;
  localparam logic [1:0] StByZero = 2'd1;
  localparam logic [1:0] StOn     = 2'd2;
  localparam logic [1:0] StEnd    = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  // quot_q starts as the dividend magnitude and shifts quotient bits in from the right.
  logic [31:0] quot_q, quot_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] divisor_q, divisor_d;
  logic        neg_quot_q, neg_quot_d;
  logic        neg_rem_q, neg_rem_d;

  logic        op1_neg, op2_neg;
  logic [31:0] op1_mag, op2_mag;
  logic [32:0] rem_shift;
  logic [32:0] rem_sub;
  logic        rem_ge;
  logic [31:0] quot_fix, rem_fix;

  // Operand magnitudes and one restoring step.
  always_comb begin
    op1_neg   = signed_div_i & opdata1_i[31];
    op2_neg   = signed_div_i & opdata2_i[31];
    op1_mag   = op1_neg ? (~opdata1_i + 32'd1) : opdata1_i;
    op2_mag   = op2_neg ? (~opdata2_i + 32'd1) : opdata2_i;
    rem_shift = {rem_q, quot_q[31]};
    rem_ge    = rem_shift >= {1'b0, divisor_q};
    rem_sub   = rem_shift - {1'b0, divisor_q};
  end

  // Next-state logic for the FSM and datapath registers.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    divisor_d  = divisor_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;

    if (annul_i) begin
      state_d    = StFree;
      cnt_d      = 5'd0;
      quot_d     = 32'd0;
      rem_d      = 32'd0;
      divisor_d  = 32'd0;
      neg_quot_d = 1'b0;
      neg_rem_d  = 1'b0;
    end else begin
      case (state_q)
        StFree: begin
          if (start_i) begin
            cnt_d = 5'd0;
            if (opdata2_i == 32'd0) begin
              state_d    = StByZero;
              quot_d     = 32'd0;
              rem_d      = 32'd0;
              neg_quot_d = 1'b0;
              neg_rem_d  = 1'b0;
            end else begin
              state_d    = StOn;
              quot_d     = op1_mag;
              rem_d      = 32'd0;
              divisor_d  = op2_mag;
              neg_quot_d = op1_neg ^ op2_neg;
              neg_rem_d  = op1_neg;
`ifdef DIV_EARLY_EXIT_EN
              // Quotient is zero; remainder re-negated at END gives back opdata1_i.
              if (op1_mag < op2_mag) begin
                state_d    = StEnd;
                quot_d     = 32'd0;
                rem_d      = op1_mag;
                neg_quot_d = 1'b0;
              end
`endif
            end
          end
        end
        StByZero: state_d = StEnd;
        StOn: begin
          quot_d = {quot_q[30:0], rem_ge};
          rem_d  = rem_ge ? rem_sub[31:0] : rem_shift[31:0];
          cnt_d  = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = StEnd;
        end
        default: begin
          if (!start_i) state_d = StFree;
        end
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StFree;
      cnt_q      <= 5'd0;
      quot_q     <= 32'd0;
      rem_q      <= 32'd0;
      divisor_q  <= 32'd0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      divisor_q  <= divisor_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
    end
  end

  // Sign fix-up and output decode; result only visible in END.
  always_comb begin
    quot_fix = neg_quot_q ? (~quot_q + 32'd1) : quot_q;
    rem_fix  = neg_rem_q ? (~rem_q + 32'd1) : rem_q;
    ready_o  = (state_q == StEnd);
    busy_o   = (state_q == StByZero) || (state_q == StOn);
    result_o = ready_o ? {rem_fix, quot_fix} : 64'd0;
  end

endmodule

// File: tb/tb_div_seq.sv
// Testbench for div_seq: directed vectors, scoreboard queue checked by a monitor.
module tb_div_seq;

  logic        clk;
  logic        rst;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];
  logic        ready_prev = 1'b0;

`ifdef DIV_EARLY_EXIT_EN
  localparam int LatSmall  = 1;
  localparam int BusySmall = 0;
`else
  localparam int LatSmall  = 33;
  localparam int BusySmall = 32;
`endif

  div_seq dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (opdata1),
    .opdata2_i    (opdata2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Monitor: on each rising ready, pop the expected result and compare.
  always @(negedge clk) begin
    if (ready && !ready_prev) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL monitor: unexpected ready, result %h, none expected", result);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if (result !== e) begin
          n_err++;
          $display("FAIL monitor result: got %h expected %h", result, e);
        end
      end
    end
    ready_prev = ready;
  end

  task automatic run_div(input string nm, input logic sg, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp_res,
                         input int exp_lat, input int exp_busy);
    int n;
    int nb;
    exp_q.push_back(exp_res);
    signed_div = sg;
    opdata1    = a;
    opdata2    = b;
    start      = 1'b1;
    n  = 0;
    nb = 0;
    while (1) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) begin
        // Operands must be ignored once sampled.
        opdata1 = $urandom;
        opdata2 = $urandom;
      end
      if (ready) break;
      if (busy) nb++;
      if (n == 5) check({nm, " result while busy"}, result, 64'd0);
      if (n >= 100) break;
    end
    check({nm, " latency"}, 64'(n), 64'(exp_lat));
    check({nm, " busy cycles"}, 64'(nb), 64'(exp_busy));
    @(posedge clk);
    #1;
    check({nm, " held result"}, {ready, result}, {1'b1, exp_res});
    start = 1'b0;
    @(posedge clk);
    #1;
    check({nm, " back to free"}, {ready, busy, result}, 66'd0);
  endtask

  initial begin
    rst        = 1'b1;
    signed_div = 1'b0;
    opdata1    = 32'd0;
    opdata2    = 32'd0;
    start      = 1'b0;
    annul      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", {ready, busy, result}, 66'd0);
    rst = 1'b0;

    run_div("u 100/7", 1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 33, 32);
    run_div("s -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 32);
    run_div("s min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 33, 32);
    run_div("s 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'h1, 32'hFFFF_FFFD}, 33, 32);
    run_div("s -7/-2", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, {32'hFFFF_FFFF, 32'h3}, 33, 32);
    run_div("u ffffffff/16", 1'b0, 32'hFFFF_FFFF, 32'h10, {32'hF, 32'h0FFF_FFFF}, 33, 32);
    run_div("u ffffffff/-1 unsigned", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'h0, 32'h1}, 33, 32);
    run_div("div by zero", 1'b0, 32'd55, 32'd0, 64'd0, 2, 1);
    run_div("u 3/10", 1'b0, 32'd3, 32'd10, {32'h3, 32'h0}, LatSmall, BusySmall);
    run_div("s -3/10", 1'b1, 32'hFFFF_FFFD, 32'd10, {32'hFFFF_FFFD, 32'h0}, LatSmall, BusySmall);

    // Annul at iteration 10 (counter=10 before edge 12).
    signed_div = 1'b0;
    opdata1    = 32'd1000;
    opdata2    = 32'd3;
    start      = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    check("busy before annul", {63'd0, busy}, 64'd1);
    annul = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    annul = 1'b0;
    check("after annul", {ready, busy, result}, 66'd0);
    run_div("after annul 1000/3", 1'b0, 32'd1000, 32'd3, {32'h1, 32'd333}, 33, 32);

    // Reset in the middle of ON.
    opdata1 = 32'd50;
    opdata2 = 32'd6;
    start   = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    rst   = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    check("mid-on reset", {ready, busy, result}, 66'd0);
    rst = 1'b0;
    run_div("after reset 50/6", 1'b0, 32'd50, 32'd6, {32'h2, 32'h8}, 33, 32);

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
